// File: rtl/bcd_pkg.sv
// Shared BCD helpers for the time-of-day counter chain (seconds/minutes/hours).
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] nib);
        return nib <= BCD_NINE;
    endfunction

    function automatic logic [BCD_W-1:0] max_tens(input int unsigned modulus);
        return BCD_W'((modulus - 1) / 10);
    endfunction

    function automatic logic [BCD_W-1:0] max_units(input int unsigned modulus);
        return BCD_W'((modulus - 1) % 10);
    endfunction

    // Binary value of a two-digit BCD pair; 8 bits covers even non-BCD nibbles.
    function automatic logic [7:0] bcd_to_bin(input logic [BCD_W-1:0] t,
                                              input logic [BCD_W-1:0] u);
        return {4'd0, t} * 8'd10 + {4'd0, u};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade BCD digit: clear > load > inc > dec, with carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rs_n,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [BCD_W-1:0] wrap_val,
    output logic [BCD_W-1:0] value,
    output logic             co
);

    logic [BCD_W-1:0] r_val;

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            r_val <= '0;
        end else if (clear) begin
            r_val <= '0;
        end else if (load) begin
            r_val <= load_val;
        end else if (inc) begin
            r_val <= (r_val == BCD_NINE) ? '0 : r_val + 4'd1;
        end else if (dec) begin
            r_val <= (r_val == '0) ? wrap_val : r_val - 4'd1;
        end
    end

    assign value = r_val;
    assign co    = (inc && r_val == BCD_NINE) || (dec && r_val == '0);

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-N up/down counter with clear, load and cascade tc.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int unsigned MODULUS = 60
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_tens,
    input  logic [BCD_W-1:0] ld_units,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units,
    output logic             tc,
    output logic             load_err
);

    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS must be in 2..100");
    end

    localparam logic [BCD_W-1:0] MAX_T = max_tens(MODULUS);
    localparam logic [BCD_W-1:0] MAX_U = max_units(MODULUS);
    localparam logic [7:0]       LAST  = 8'(MODULUS - 1);

    logic             w_cnt;
    logic             w_up_wrap;
    logic             w_dn_wrap;
    logic             w_ld_ok;
    logic             w_clear;
    logic             w_load;
    logic             w_u_co;
    logic             w_t_co;
    logic [BCD_W-1:0] w_u_wrap_val;
    logic             r_load_err;

    assign w_cnt     = en & ~clr & ~load;
    assign w_up_wrap = w_cnt & up & (tens == MAX_T) & (units == MAX_U);
    // A tens borrow only happens from 00, so it doubles as the down-wrap flag.
    assign w_dn_wrap = ~up & w_t_co;
    assign w_ld_ok   = bcd_valid(ld_tens) & bcd_valid(ld_units)
                     & (bcd_to_bin(ld_tens, ld_units) <= LAST);
    assign w_clear   = clr | (load & ~w_ld_ok) | w_up_wrap;
    assign w_load    = ~clr & load & w_ld_ok;
    // Units underflow from x0 borrows to 9, but from 00 it lands on MAX_U.
    assign w_u_wrap_val = (tens == '0) ? MAX_U : BCD_NINE;

    bcd_digit u_units (
        .clk      (clk),
        .rs_n     (rs_n),
        .clear    (w_clear),
        .load     (w_load),
        .load_val (ld_units),
        .inc      (w_cnt & up),
        .dec      (w_cnt & ~up),
        .wrap_val (w_u_wrap_val),
        .value    (units),
        .co       (w_u_co)
    );

    bcd_digit u_tens (
        .clk      (clk),
        .rs_n     (rs_n),
        .clear    (w_clear),
        .load     (w_load),
        .load_val (ld_tens),
        .inc      (w_u_co & up),
        .dec      (w_u_co & ~up),
        .wrap_val (MAX_T),
        .value    (tens),
        .co       (w_t_co)
    );

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= ~clr & load & ~w_ld_ok;
        end
    end

    assign tc       = w_up_wrap | w_dn_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter at moduli 60 (cascaded pair), 24, 7 and 100.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       rs_n = 1'b0;
    int         total = 0;
    int         bad = 0;

    // Instance A (mod 60) and cascaded instance B (mod 60) fed by A's tc.
    logic       en_a = 0, up_a = 1, clr_a = 0, load_a = 0;
    logic [3:0] ldt_a = 0, ldu_a = 0, tens_a, units_a, tens_b, units_b;
    logic       tc_a, err_a, tc_b, err_b;

    // Instances C (mod 24), D (mod 7), E (mod 100) share control lines, own enables.
    logic       up_s = 1, clr_s = 0, load_s = 0;
    logic [3:0] ldt_s = 0, ldu_s = 0;
    logic       en_c = 0, en_d = 0, en_e = 0;
    logic [3:0] tens_c, units_c, tens_d, units_d, tens_e, units_e;
    logic       tc_c, err_c, tc_d, err_d, tc_e, err_e;

    always #5 clk = ~clk;

    bcd_mod_counter #(.MODULUS(60)) dut_a (
        .clk(clk), .rs_n(rs_n), .en(en_a), .up(up_a), .clr(clr_a), .load(load_a),
        .ld_tens(ldt_a), .ld_units(ldu_a), .tens(tens_a), .units(units_a),
        .tc(tc_a), .load_err(err_a));

    bcd_mod_counter #(.MODULUS(60)) dut_b (
        .clk(clk), .rs_n(rs_n), .en(tc_a), .up(1'b1), .clr(1'b0), .load(1'b0),
        .ld_tens(4'd0), .ld_units(4'd0), .tens(tens_b), .units(units_b),
        .tc(tc_b), .load_err(err_b));

    bcd_mod_counter #(.MODULUS(24)) dut_c (
        .clk(clk), .rs_n(rs_n), .en(en_c), .up(up_s), .clr(clr_s), .load(load_s),
        .ld_tens(ldt_s), .ld_units(ldu_s), .tens(tens_c), .units(units_c),
        .tc(tc_c), .load_err(err_c));

    bcd_mod_counter #(.MODULUS(7)) dut_d (
        .clk(clk), .rs_n(rs_n), .en(en_d), .up(up_s), .clr(clr_s), .load(load_s),
        .ld_tens(ldt_s), .ld_units(ldu_s), .tens(tens_d), .units(units_d),
        .tc(tc_d), .load_err(err_d));

    bcd_mod_counter #(.MODULUS(100)) dut_e (
        .clk(clk), .rs_n(rs_n), .en(en_e), .up(up_s), .clr(clr_s), .load(load_s),
        .ld_tens(ldt_s), .ld_units(ldu_s), .tens(tens_e), .units(units_e),
        .tc(tc_e), .load_err(err_e));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({tens_a, units_a, err_a, tens_b, units_b} !== 17'h0) begin
            bad++;
            $display("FAIL reset_state a=%h%h err=%b b=%h%h exp 00/0/00",
                     tens_a, units_a, err_a, tens_b, units_b);
        end
        step();
        rs_n = 1'b1;
        en_a = 1'b1; up_a = 1'b1;
        repeat (37) step();
        total++;
        if ({tens_a, units_a} !== 8'h37) begin
            bad++;
            $display("FAIL count_to_37 got %h%h exp 37", tens_a, units_a);
        end
        #2 rs_n = 1'b0;
        #1;
        total++;
        if ({tens_a, units_a, err_a} !== 9'h0) begin
            bad++;
            $display("FAIL async_reset got %h%h err=%b exp 00/0", tens_a, units_a, err_a);
        end
        rs_n = 1'b1;
        step();
        total++;
        if ({tens_a, units_a} !== 8'h01) begin
            bad++;
            $display("FAIL after_release got %h%h exp 01", tens_a, units_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_up_wrap();
        load_a = 1'b1; ldt_a = 4'd5; ldu_a = 4'd8;
        step();
        load_a = 1'b0;
        total++;
        if ({tens_a, units_a, err_a} !== {8'h58, 1'b0}) begin
            bad++;
            $display("FAIL load_58 got %h%h err=%b exp 58/0", tens_a, units_a, err_a);
        end
        en_a = 1'b1; up_a = 1'b1;
        #1;
        total++;
        if (tc_a !== 1'b0) begin
            bad++;
            $display("FAIL tc_at_58 got %b exp 0", tc_a);
        end
        step();
        total++;
        if ({tens_a, units_a, tc_a} !== {8'h59, 1'b1}) begin
            bad++;
            $display("FAIL at_59 got %h%h tc=%b exp 59/1", tens_a, units_a, tc_a);
        end
        step();
        total++;
        if ({tens_a, units_a, tc_a, tens_b, units_b} !== {8'h00, 1'b0, 8'h01}) begin
            bad++;
            $display("FAIL wrap_00 got %h%h tc=%b b=%h%h exp 00/0 b=01",
                     tens_a, units_a, tc_a, tens_b, units_b);
        end
        step();
        total++;
        if ({tens_a, units_a, tens_b, units_b} !== 16'h0101) begin
            bad++;
            $display("FAIL cascade_once got a=%h%h b=%h%h exp a=01 b=01",
                     tens_a, units_a, tens_b, units_b);
        end
        en_a = 1'b0;
    endtask

    task automatic test_down_wrap();
        clr_s = 1'b1;
        step();
        clr_s = 1'b0; up_s = 1'b0; en_c = 1'b1;
        #1;
        total++;
        if ({tens_c, units_c, tc_c} !== {8'h00, 1'b1}) begin
            bad++;
            $display("FAIL down_tc_at_00 got %h%h tc=%b exp 00/1", tens_c, units_c, tc_c);
        end
        step();
        total++;
        if ({tens_c, units_c, tc_c} !== {8'h23, 1'b0}) begin
            bad++;
            $display("FAIL down_wrap_23 got %h%h tc=%b exp 23/0", tens_c, units_c, tc_c);
        end
        step();
        total++;
        if ({tens_c, units_c} !== 8'h22) begin
            bad++;
            $display("FAIL down_22 got %h%h exp 22", tens_c, units_c);
        end
        load_s = 1'b1; ldt_s = 4'd2; ldu_s = 4'd0;
        step();
        load_s = 1'b0;
        total++;
        if ({tens_c, units_c} !== 8'h20) begin
            bad++;
            $display("FAIL load_20 got %h%h exp 20", tens_c, units_c);
        end
        step();
        total++;
        if ({tens_c, units_c} !== 8'h19) begin
            bad++;
            $display("FAIL borrow_19 got %h%h exp 19", tens_c, units_c);
        end
        en_c = 1'b0; up_s = 1'b1;
    endtask

    task automatic test_load();
        logic [3:0] lt [4] = '{4'd4, 4'd6, 4'd2, 4'd5};
        logic [3:0] lu [4] = '{4'd5, 4'd3, 4'hA, 4'd9};
        logic [8:0] ex [4] = '{{8'h45, 1'b0}, {8'h00, 1'b1}, {8'h00, 1'b1}, {8'h59, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            load_a = 1'b1; ldt_a = lt[i]; ldu_a = lu[i];
            step();
            load_a = 1'b0;
            total++;
            if ({tens_a, units_a, err_a} !== ex[i]) begin
                bad++;
                $display("FAIL load_%h%h got %h%h err=%b exp %h err=%b",
                         lt[i], lu[i], tens_a, units_a, err_a, ex[i][8:1], ex[i][0]);
            end
            step();
            total++;
            if ({tens_a, units_a, err_a} !== {ex[i][8:1], 1'b0}) begin
                bad++;
                $display("FAIL load_hold_%h%h got %h%h err=%b exp %h err=0",
                         lt[i], lu[i], tens_a, units_a, err_a, ex[i][8:1]);
            end
        end
    endtask

    task automatic test_priority();
        clr_a = 1'b1; load_a = 1'b1; ldt_a = 4'd4; ldu_a = 4'd5; en_a = 1'b1; up_a = 1'b1;
        #1;
        total++;
        if (tc_a !== 1'b0) begin
            bad++;
            $display("FAIL prio_clr_tc got %b exp 0", tc_a);
        end
        step();
        total++;
        if ({tens_a, units_a, err_a} !== 9'h0) begin
            bad++;
            $display("FAIL prio_clr got %h%h err=%b exp 00/0", tens_a, units_a, err_a);
        end
        clr_a = 1'b0; en_a = 1'b0; ldt_a = 4'd5; ldu_a = 4'd9;
        step();
        ldt_a = 4'd1; ldu_a = 4'd2; en_a = 1'b1;
        #1;
        total++;
        if ({tens_a, units_a, tc_a} !== {8'h59, 1'b0}) begin
            bad++;
            $display("FAIL prio_load_tc got %h%h tc=%b exp 59/0", tens_a, units_a, tc_a);
        end
        step();
        total++;
        if ({tens_a, units_a} !== 8'h12) begin
            bad++;
            $display("FAIL prio_load_no_count got %h%h exp 12", tens_a, units_a);
        end
        load_a = 1'b0; en_a = 1'b0;
    endtask

    task automatic test_small_modulus();
        logic [3:0] exp_u;
        clr_s = 1'b1;
        step();
        clr_s = 1'b0; up_s = 1'b1; en_d = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            total++;
            if (tc_d !== (units_d == 4'd6)) begin
                bad++;
                $display("FAIL mod7_tc step%0d got %b at %h%h", i, tc_d, tens_d, units_d);
            end
            step();
            exp_u = 4'((i + 1) % 7);
            total++;
            if ({tens_d, units_d} !== {4'd0, exp_u}) begin
                bad++;
                $display("FAIL mod7_step%0d got %h%h exp 0%h", i, tens_d, units_d, exp_u);
            end
        end
        en_d = 1'b0;
    endtask

    task automatic test_full_modulus();
        load_s = 1'b1; ldt_s = 4'd9; ldu_s = 4'd8;
        step();
        load_s = 1'b0; up_s = 1'b1; en_e = 1'b1;
        total++;
        if ({tens_e, units_e, err_e} !== {8'h98, 1'b0}) begin
            bad++;
            $display("FAIL mod100_load got %h%h err=%b exp 98/0", tens_e, units_e, err_e);
        end
        step();
        total++;
        if ({tens_e, units_e, tc_e} !== {8'h99, 1'b1}) begin
            bad++;
            $display("FAIL mod100_99 got %h%h tc=%b exp 99/1", tens_e, units_e, tc_e);
        end
        step();
        total++;
        if ({tens_e, units_e, tc_e} !== {8'h00, 1'b0}) begin
            bad++;
            $display("FAIL mod100_wrap got %h%h tc=%b exp 00/0", tens_e, units_e, tc_e);
        end
        up_s = 1'b0;
        #1;
        total++;
        if (tc_e !== 1'b1) begin
            bad++;
            $display("FAIL mod100_down_tc got %b exp 1", tc_e);
        end
        step();
        total++;
        if ({tens_e, units_e} !== 8'h99) begin
            bad++;
            $display("FAIL mod100_down_wrap got %h%h exp 99", tens_e, units_e);
        end
        en_e = 1'b0; up_s = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_priority();
        test_small_modulus();
        test_full_modulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
